// File: rtl/mux_2_1.sv
// 2:1 data select with a valid qualifier; optional output register.
// Latency: 1 cycle when REGISTERED=1, 0 cycles when REGISTERED=0.
// Backpressure: none; every valid input is accepted.
module mux_2_1 #(
    parameter int WIDTH      = 4,
    parameter int REGISTERED = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] f,
    output logic             out_valid
);

    logic [WIDTH-1:0] sel_dat;

    always_comb begin
        sel_dat = a;
        if (sel) begin
            sel_dat = b;
        end
    end

    generate
        if (REGISTERED != 0) begin : g_reg
            logic [WIDTH-1:0] f_q;
            logic [WIDTH-1:0] f_d;
            logic             vld_q;
            logic             vld_d;

            // Data holds through idle cycles; valid flag only lives one cycle.
            always_comb begin
                f_d   = f_q;
                vld_d = in_valid;
                if (in_valid) begin
                    f_d = sel_dat;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    f_q   <= '0;
                    vld_q <= 1'b0;
                end else begin
                    f_q   <= f_d;
                    vld_q <= vld_d;
                end
            end

            assign f         = f_q;
            assign out_valid = vld_q;
        end else begin : g_comb
            logic unused_clk_rst;

            // Clock and reset are intentionally ignored in the pass-through build.
            assign unused_clk_rst = clk ^ rst_n;
            assign f              = sel_dat;
            assign out_valid      = in_valid;
        end
    endgenerate

endmodule

// File: tb/tb_mux_2_1.sv
// Directed table-driven bench for mux_2_1, registered and combinational builds.
module tb_mux_2_1;

    logic       clk;
    logic       rst_n;
    logic [3:0] a, b, f;
    logic       sel, in_valid, out_valid;
    logic [3:0] a_c, b_c, f_c;
    logic       sel_c, in_valid_c, out_valid_c;

    int total = 0;
    int bad   = 0;

    mux_2_1 #(.WIDTH(4), .REGISTERED(1)) u_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .in_valid  (in_valid),
        .f         (f),
        .out_valid (out_valid)
    );

    mux_2_1 #(.WIDTH(4), .REGISTERED(0)) u_comb (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a_c),
        .b         (b_c),
        .sel       (sel_c),
        .in_valid  (in_valid_c),
        .f         (f_c),
        .out_valid (out_valid_c)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sel;
        logic       vld;
        logic [3:0] ef;
        logic       ev;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        // a, b, sel, in_valid -> f, out_valid one edge later
        vecs[0]  = '{4'b1010, 4'b0101, 1'b0, 1'b1, 4'b1010, 1'b1};
        vecs[1]  = '{4'b1010, 4'b0101, 1'b1, 1'b1, 4'b0101, 1'b1};
        vecs[2]  = '{4'b1111, 4'b0000, 1'b0, 1'b1, 4'b1111, 1'b1};
        vecs[3]  = '{4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1};
        vecs[4]  = '{4'b0011, 4'b1100, 1'b0, 1'b1, 4'b0011, 1'b1};
        vecs[5]  = '{4'b0011, 4'b1100, 1'b1, 1'b1, 4'b1100, 1'b1};
        vecs[6]  = '{4'b0101, 4'b1010, 1'b0, 1'b0, 4'b1100, 1'b0};
        vecs[7]  = '{4'b0101, 4'b1010, 1'b1, 1'b0, 4'b1100, 1'b0};
        vecs[8]  = '{4'b0110, 4'b1001, 1'b0, 1'b1, 4'b0110, 1'b1};
        vecs[9]  = '{4'b0110, 4'b1001, 1'b1, 1'b1, 4'b1001, 1'b1};
        vecs[10] = '{4'b1111, 4'b0000, 1'b0, 1'b1, 4'b1111, 1'b1};

        clk        = 1'b0;
        rst_n      = 1'b0;
        a          = '0;
        b          = '0;
        sel        = 1'b0;
        in_valid   = 1'b0;
        a_c        = '0;
        b_c        = '0;
        sel_c      = 1'b0;
        in_valid_c = 1'b0;

        #2;
        check("reset_f", f, 4'b0000);
        check("reset_vld", out_valid, 1'b0);

        // Pass-through build must ignore the reset that is still asserted.
        a_c = 4'b1010; b_c = 4'b0101; sel_c = 1'b0; in_valid_c = 1'b1;
        #1;
        check("comb_sel0_f", f_c, 4'b1010);
        check("comb_sel0_vld", out_valid_c, 1'b1);
        sel_c = 1'b1;
        #1;
        check("comb_sel1_f", f_c, 4'b0101);
        in_valid_c = 1'b0;
        #1;
        check("comb_vld0", out_valid_c, 1'b0);
        check("comb_vld0_f", f_c, 4'b0101);
        sel_c = 1'b0;
        #1;
        check("comb_sel0_again_f", f_c, 4'b1010);

        // Edges during reset must not load anything.
        a = 4'b1111; sel = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        check("in_reset_f", f, 4'b0000);
        check("in_reset_vld", out_valid, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (i != 0) @(negedge clk);
            a        = vecs[i].a;
            b        = vecs[i].b;
            sel      = vecs[i].sel;
            in_valid = vecs[i].vld;
            @(posedge clk); #1;
            check($sformatf("vec%0d_f", i), f, vecs[i].ef);
            check($sformatf("vec%0d_vld", i), out_valid, vecs[i].ev);
        end

        // Asynchronous reset between edges clears the outputs immediately.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_f", f, 4'b0000);
        check("async_rst_vld", out_valid, 1'b0);

        @(negedge clk);
        rst_n = 1'b1; a = 4'b1010; b = 4'b0101; sel = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        check("post_rst_f", f, 4'b1010);
        check("post_rst_vld", out_valid, 1'b1);

        @(negedge clk);
        in_valid = 1'b0; sel = 1'b1;
        @(posedge clk); #1;
        check("post_rst_hold_f", f, 4'b1010);
        check("post_rst_hold_vld", out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_2_1.md
MUX_2_1 -- requirements
Module: mux_2_1

Interface
REQ-001: Parameter WIDTH, default 4, SHALL set the bit width of data buses a, b and f.
REQ-002: Parameter REGISTERED, default 1, SHALL select the output style: 1 = registered output, 0 = combinational output.
REQ-003: Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004: Port rst_n, input, 1 bit, SHALL be the reset: asynchronous and active-low.
REQ-005: Port a, input, WIDTH bits, SHALL be data input 0.
REQ-006: Port b, input, WIDTH bits, SHALL be data input 1.
REQ-007: Port sel, input, 1 bit, SHALL be the select: 0 picks a, 1 picks b.
REQ-008: Port in_valid, input, 1 bit, SHALL qualify a, b and sel as valid this cycle.
REQ-009: Port f, output, WIDTH bits, SHALL be the selected data output.
REQ-010: Port out_valid, output, 1 bit, SHALL indicate f carries a result from a valid input.

Function
REQ-011: Selection SHALL be bitwise-exact: f = a when sel=0 and f = b when sel=1, with no width extension or truncation.
REQ-012: Registered mode (REGISTERED=1):
- On a rising clk edge with in_valid=1, f SHALL load the selected input and out_valid SHALL be set to 1.
- Latency SHALL be exactly 1 cycle.
REQ-013: Registered mode, idle cycles: on a rising edge with in_valid=0, f SHALL hold its previous value and out_valid SHALL be cleared to 0.
REQ-014: Registered mode: a sel change alone, with a and b stable and in_valid=1, SHALL update f on the next edge to the newly selected input.
REQ-015: Registered mode: inputs sampled on the same edge as reset deassertion SHALL be captured normally on the first edge where rst_n=1.
REQ-016: Combinational mode (REGISTERED=0):
- f SHALL equal the selected input continuously, with zero-cycle latency.
- out_valid SHALL equal in_valid.
- rst_n and clk SHALL have no effect.
REQ-017: If sel is X or Z, f is unspecified; no X-propagation handling is required.
REQ-018: The block SHALL contain no other state, no backpressure and no ready signal; every valid input is accepted.

Reset
REQ-019: While rst_n=0 in registered mode, f SHALL be all zeros and out_valid SHALL be 0, regardless of clk.
REQ-020: Assertion of rst_n mid-operation SHALL clear f and out_valid immediately, without waiting for a clock edge.
REQ-021: After rst_n deasserts, the first valid edge SHALL produce a normal result; no warm-up cycles are required.

Verification
REQ-022: Basic select, WIDTH=4, registered: a=1010, b=0101, in_valid=1.
- sel=0 -> one edge later f=1010, out_valid=1.
- Then sel=1 -> next edge f=0101.
REQ-023: Extreme patterns: a=1111, b=0000.
- sel=0 -> f=1111.
- sel=1 -> f=0000.
- Each result appears after exactly one edge.
REQ-024: Complementary patterns: a=0011, b=1100.
- sel=0 -> f=0011.
- sel=1 -> f=1100.
REQ-025: Hold: after f=1100 with out_valid=1, drive in_valid=0, a=0101, b=1010, toggle sel.
- f SHALL stay 1100.
- out_valid SHALL drop to 0 on the next edge.
REQ-026: Async reset: with f=1111 and out_valid=1, pull rst_n low between clock edges.
- f SHALL become 0000 and out_valid 0 before the next edge.
- After release, a=1010, sel=0, in_valid=1 SHALL give f=1010 one edge later.
REQ-027: Combinational build (REGISTERED=0), no clock: a=1010, b=0101, toggle sel.
- f SHALL follow within the same delta cycle: sel=0 -> 1010, sel=1 -> 0101.
- out_valid SHALL follow in_valid.
